multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// ============================================================================
//  Module   : multicycle_alu
//  Purpose  : Valid/ready ALU; single-cycle ops plus iterative MUL/DIVU/REMU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int c_shw = $clog2(WIDTH);
    localparam logic [c_shw-1:0] c_last = {c_shw{1'b1}};
    localparam logic [c_shw-1:0] c_one  = {{(c_shw-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [4:0] c_op_sub  = 5'b10000;
    localparam logic [4:0] c_op_and  = 5'b00111;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_xor  = 5'b00100;
    localparam logic [4:0] c_op_sll  = 5'b00001;
    localparam logic [4:0] c_op_srl  = 5'b00101;
    localparam logic [4:0] c_op_sra  = 5'b10101;
    localparam logic [4:0] c_op_slt  = 5'b00010;
    localparam logic [4:0] c_op_sltu = 5'b00011;
    localparam logic [4:0] c_op_mul  = 5'b01000;
    localparam logic [4:0] c_op_divu = 5'b01100;
    localparam logic [4:0] c_op_remu = 5'b01110;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [c_shw-1:0] r_cnt;
    logic             r_is_mul;
    logic             r_is_rem;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;

    logic [WIDTH-1:0] w_alu;
    logic [c_shw-1:0] w_sh;
    logic             w_multi;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_mc;

    assign w_sh    = b[c_shw-1:0];
    assign w_multi = (opcode == c_op_mul) || (opcode == c_op_divu) || (opcode == c_op_remu);

    // Single-cycle results come straight from the accepted inputs; unknown opcodes add.
    always_comb begin
        w_alu = a + b;
        case (opcode)
            c_op_sub:  w_alu = a - b;
            c_op_and:  w_alu = a & b;
            c_op_or:   w_alu = a | b;
            c_op_xor:  w_alu = a ^ b;
            c_op_sll:  w_alu = a << w_sh;
            c_op_srl:  w_alu = a >> w_sh;
            c_op_sra:  w_alu = $signed(a) >>> w_sh;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            default:   w_alu = a + b;
        endcase
    end

    // MUL: r_a is the left-shifting multiplicand, r_b[r_cnt] the current multiplier bit.
    // DIV: r_a shifts dividend bits out the top and quotient bits in the bottom,
    // r_acc is the partial remainder. A zero divisor naturally yields all-ones / a.
    assign w_mul_acc = r_acc + (r_b[r_cnt] ? r_a : {WIDTH{1'b0}});
    assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx  = {r_a[WIDTH-2:0], w_ge};
    assign w_mc      = r_is_mul ? w_mul_acc : (r_is_rem ? w_rem_nx : w_quo_nx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_y      <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_is_mul <= (opcode == c_op_mul);
                        r_is_rem <= (opcode == c_op_remu);
                        if (w_multi) begin
                            r_state <= c_busy;
                        end else begin
                            r_y     <= w_alu;
                            r_zero  <= (w_alu == '0);
                            r_state <= c_done;
                        end
                    end
                end
                c_busy: begin
                    r_cnt <= r_cnt + c_one;
                    r_a   <= r_is_mul ? (r_a << 1) : w_quo_nx;
                    r_acc <= r_is_mul ? w_mul_acc : w_rem_nx;
                    if (r_cnt == c_last) begin
                        r_y     <= w_mc;
                        r_zero  <= (w_mc == '0);
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign y         = r_y;
    assign zero      = r_zero;

endmodule

`default_nettype wire
